s4_fmap_pingpong: RTL and testbench
===================================

// Module: s4_fmap_pingpong
// PURPOSE
//  Downstream of the S4 2x2 max-pool stage. Captures the 25 pooled 16-channel
//  pixel vectors (5x5 map) per image into a ping-pong buffer. Replays each
//  completed map to the C5 MAC engine as a 400-beat valid/ready stream.
//  Upstream has no backpressure; double buffering absorbs the next image while
//  C5 consumes the current one.
// PARAMETERS
//  OUT_BITS  16  signed pixel width, identical to the pool stage output
//  MAP_W      5  S4 map width/height; POS_N = MAP_W*MAP_W = 25 vectors/image
//  CH_N      16  channels per vector (fixed by the 16*OUT_BITS packing)
// PORTS
//  clk          in   1              clock
//  rst_n        in   1              reset, synchronous, active-low
//  in_valid     in   1              one pooled vector present this cycle
//  in_pix16     in   16*OUT_BITS    {ch15..ch0}; ch k at [k*OUT_BITS +: OUT_BITS]
//  out_valid    out  1              out_data/out_pos/out_ch/out_last valid
//  out_ready    in   1              C5 accepts the beat
//  out_data     out  OUT_BITS       signed pixel
//  out_pos      out  5              raster position 0..24 (row*5+col)
//  out_ch       out  4              channel 0..15
//  out_last     out  1              final beat of the map (pos 24, ch 15)
//  bufs_full    out  2              per-bank full flags (debug/status)
//  ovf          out  1              sticky: vector dropped, both banks full
// BEHAVIOUR
//  Reset: all outputs 0. wr_bank=0, wr_pos=0, rd_bank=0, rd_pos=0, rd_ch=0.
//   Reset is honoured mid-fill or mid-stream; partial data is discarded.
//   Storage contents need no reset.
//  Write side, per bank: EMPTY -> FILLING -> FULL.
//   in_valid with bank[wr_bank] not full: store at [wr_bank][wr_pos]; wr_pos++.
//   On the write with wr_pos==24: set full[wr_bank], wr_pos=0, toggle wr_bank.
//   in_valid while full[wr_bank]=1: drop the vector, set ovf (cleared only by
//   reset). wr_pos is unchanged.
//  Read FSM: IDLE / STREAM.
//   IDLE: when full[rd_bank]=1, the next cycle enters STREAM with out_valid=1.
//    The first beat is pos0 ch0. Latency: 25th write at edge T -> out_valid at T+1.
//   STREAM: outputs are registered and held stable while out_valid & !out_ready.
//    Beat order: position-major, channel-minor (pos0 ch0..ch15, pos1 ch0...).
//    out_data = bank[rd_bank][out_pos][out_ch].
//   Handshake (out_valid&out_ready) advances one beat per cycle. Full throughput
//    is 400 cycles/map.
//   Handshake on out_last: clear full[rd_bank], toggle rd_bank.
//    If the other bank is already full, its pos0 ch0 beat is presented the next
//    cycle with no bubble. Otherwise go to IDLE and deassert out_valid.
//  Simultaneous events:
//   - Write completing bank A while the out_last handshake frees bank B: both
//     take effect; no drop.
//   - A write into the bank freed this same cycle is NOT allowed. full clears at
//     the edge, so a vector arriving that cycle into a still-full wr_bank is
//     dropped (ovf).
//   - The write side never touches rd_bank while it is FULL. No read/write hazard.
//  Widths: data is passed through bit-exact, with no saturation or sign change.
//   Counters wrap only at the stated bounds (24, 15).
// STRUCTURE
//  Shared package/header: OUT_BITS, MAP_W, POS_N=25, CH_N=16, BEAT_N=400,
//   read FSM state encodings (S_IDLE, S_STREAM).
//  Sub-module s4_pp_bank: one 25 x (16*OUT_BITS) register/LUTRAM bank.
//   Single write port, combinational read by pos, instantiated twice.
//   Top holds the write counter, read FSM, lane mux and output register.
// TESTING
//  1 Reset then 25 vectors, ch k of pos p = p*16+k, out_ready=1.
//    -> out_valid at T+1; 400 beats with out_data = beat index 0..399.
//    -> out_last only on beat 399; bufs_full returns to 00.
//  2 Same image with out_ready toggling 1/0 every cycle.
//    -> identical data sequence; outputs stable during every stall.
//    -> 799 cycles from first beat to out_last handshake.
//  3 Two images back-to-back (image 2 = image 1 + 1000) with out_ready=1.
//    -> beat 400 (image 2, pos0 ch0 = 1000) follows beat 399 with no bubble.
//  4 out_ready=0, feed 3 images.
//    -> bufs_full=11 after 50 vectors.
//    -> vectors 51..75 dropped, ovf=1, wr_pos stays 0.
//    -> after release, image 1 then image 2 stream intact.
//  5 Negative data (ch k = -32768+k, 16'h8000+k): bit-exact on out_data.
//  6 rst_n low for 1 cycle mid-stream (beat 137) and mid-fill (pos 12).
//    -> next cycle: all outputs 0, bufs_full=00.
//    -> a fresh 25-vector image then streams correctly from pos0 ch0.

Source files
------------

// File: rtl/s4_fmap_pingpong_pkg.sv
// Shared constants, types and read-FSM encodings for the S4 feature-map ping-pong buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package s4_fmap_pingpong_pkg;

  localparam int OUT_BITS = 16;               // signed pixel width from the pool stage
  localparam int MAP_W    = 5;                // S4 map is MAP_W x MAP_W
  localparam int POS_N    = MAP_W * MAP_W;    // 25 vectors per image
  localparam int CH_N     = 16;               // channels per vector
  localparam int BEAT_N   = POS_N * CH_N;     // 400 beats per map
  localparam int POS_W    = $clog2(POS_N);
  localparam int CH_W     = $clog2(CH_N);
  localparam int VEC_W    = CH_N * OUT_BITS;

  typedef logic [VEC_W-1:0]           vec_t;
  typedef logic signed [OUT_BITS-1:0] pix_t;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } rd_state_e;

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(POS_N - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH_N - 1);

  // Channel k lives at [k*OUT_BITS +: OUT_BITS] of a packed vector.
  function automatic pix_t lane(input vec_t v, input logic [CH_W-1:0] ch);
    return v[int'(ch) * OUT_BITS +: OUT_BITS];
  endfunction

endpackage

// File: rtl/s4_fmap_pingpong_if.sv
// Beat stream from the ping-pong buffer to the C5 MAC engine.
// Latency: n/a (wires only).
// Backpressure: master holds a beat while out_valid & !out_ready.
// Ports: master drives out_valid/out_data/out_pos/out_ch/out_last, slave drives out_ready.
interface s4_fmap_pingpong_if;
  import s4_fmap_pingpong_pkg::*;

  logic             out_valid;
  logic             out_ready;
  pix_t             out_data;
  logic [POS_W-1:0] out_pos;
  logic [CH_W-1:0]  out_ch;
  logic             out_last;

  modport master (output out_valid, out_data, out_pos, out_ch, out_last,
                  input  out_ready);
  modport slave  (input  out_valid, out_data, out_pos, out_ch, out_last,
                  output out_ready);
endinterface

// File: rtl/s4_pp_bank.sv
// One 25-entry bank of pooled 16-channel vectors; single write port, combinational read.
// Latency: write lands at the clock edge, read is same-cycle by position.
// Backpressure: none; the top only writes a bank that is not full.
// Ports: clk; we_i/wpos_i/wdat_i write port; rpos_i -> rdat_o read port.
module s4_pp_bank
  import s4_fmap_pingpong_pkg::*;
(
  input  logic             clk,
  input  logic             we_i,
  input  logic [POS_W-1:0] wpos_i,
  input  vec_t             wdat_i,
  input  logic [POS_W-1:0] rpos_i,
  output vec_t             rdat_o
);

  // Contents carry no reset; the full flags in the top say what is valid.
  vec_t mem_q [POS_N];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wpos_i] <= wdat_i;
    end
  end

  assign rdat_o = mem_q[rpos_i];

endmodule

// File: rtl/s4_fmap_pingpong.sv
// Captures 25 pooled vectors per image into two banks and replays each full bank as 400 beats.
// Latency: 25th write at edge T -> first beat (pos0 ch0) valid at T+1; one beat per cycle.
// Backpressure: out_ready stalls the stream; no upstream stall, vectors into a full bank are dropped (ovf).
// Ports: clk, rst_n (sync, active-low); in_valid_i/in_pix16_i pooled vectors; ob beat stream;
//        bufs_full_o per-bank full flags; ovf_o sticky drop flag.
module s4_fmap_pingpong
  import s4_fmap_pingpong_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  input  vec_t                in_pix16_i,
  s4_fmap_pingpong_if.master  ob,
  output logic [1:0]          bufs_full_o,
  output logic                ovf_o
);

  // Write side
  logic             wr_bank_q;
  logic [POS_W-1:0] wr_pos_q;
  logic [1:0]       full_q, full_d;
  logic             ovf_q;

  // Read side
  rd_state_e        state_q, state_d;
  logic             rd_bank_q, rd_bank_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [POS_W-1:0] out_pos_q, out_pos_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  pix_t             out_data_q;
  logic             load;

  logic wr_blocked, wr_en, wr_done, hs, rd_done;
  vec_t rd_vec [2];

  assign wr_blocked = full_q[wr_bank_q];
  assign wr_en      = in_valid_i & ~wr_blocked;
  assign wr_done    = wr_en & (wr_pos_q == POS_LAST);
  assign hs         = out_valid_q & ob.out_ready;
  assign rd_done    = hs & out_last_q;

  // Banks are read at the position of the beat being loaded next, so the
  // output register always captures the matching data.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    s4_pp_bank u_bank (
      .clk    (clk),
      .we_i   (wr_en && (wr_bank_q == 1'(b))),
      .wpos_i (wr_pos_q),
      .wdat_i (in_pix16_i),
      .rpos_i (out_pos_d),
      .rdat_o (rd_vec[b])
    );
  end

  // A completing write and a finishing read always hit different banks:
  // one needs the bank empty, the other needs it full.
  always_comb begin
    full_d = full_q;
    if (wr_done) full_d[wr_bank_q] = 1'b1;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
  end

  always_comb begin
    load        = 1'b0;
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    out_valid_d = out_valid_q;
    out_pos_d   = out_pos_q;
    out_ch_d    = out_ch_q;
    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          load        = 1'b1;
          state_d     = S_STREAM;
          out_valid_d = 1'b1;
          out_pos_d   = '0;
          out_ch_d    = '0;
        end
      end
      S_STREAM: begin
        if (hs) begin
          load = 1'b1;
          if (out_last_q) begin
            // Chain straight into the other bank only if it is already full;
            // a bank completing this same edge is picked up from IDLE.
            rd_bank_d = ~rd_bank_q;
            out_pos_d = '0;
            out_ch_d  = '0;
            if (!full_q[~rd_bank_q]) begin
              state_d     = S_IDLE;
              out_valid_d = 1'b0;
            end
          end else if (out_ch_q == CH_LAST) begin
            out_ch_d  = '0;
            out_pos_d = out_pos_q + POS_W'(1);
          end else begin
            out_ch_d  = out_ch_q + CH_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    out_last_d = out_valid_d && (out_pos_d == POS_LAST) && (out_ch_d == CH_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank_q   <= 1'b0;
      wr_pos_q    <= '0;
      full_q      <= '0;
      ovf_q       <= 1'b0;
      state_q     <= S_IDLE;
      rd_bank_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pos_q   <= '0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else begin
      full_q <= full_d;
      if (in_valid_i && wr_blocked) ovf_q <= 1'b1;
      if (wr_en) begin
        if (wr_done) begin
          wr_pos_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_pos_q  <= wr_pos_q + POS_W'(1);
        end
      end
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      if (load) begin
        out_valid_q <= out_valid_d;
        out_last_q  <= out_last_d;
        out_pos_q   <= out_pos_d;
        out_ch_q    <= out_ch_d;
        out_data_q  <= out_valid_d ? lane(rd_vec[rd_bank_d], out_ch_d) : '0;
      end
    end
  end

  assign ob.out_valid = out_valid_q;
  assign ob.out_data  = out_data_q;
  assign ob.out_pos   = out_pos_q;
  assign ob.out_ch    = out_ch_q;
  assign ob.out_last  = out_last_q;
  assign bufs_full_o  = full_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_s4_fmap_pingpong.sv
module tb_s4_fmap_pingpong;
  import s4_fmap_pingpong_pkg::*;

  typedef struct packed {
    logic [OUT_BITS-1:0] d;
    logic [POS_W-1:0]    p;
    logic [CH_W-1:0]     c;
    logic                l;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  vec_t       in_pix16 = '0;
  logic [1:0] bufs_full;
  logic       ovf;

  s4_fmap_pingpong_if ob ();

  s4_fmap_pingpong dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_pix16_i  (in_pix16),
    .ob          (ob),
    .bufs_full_o (bufs_full),
    .ovf_o       (ovf)
  );

  always #5 clk = ~clk;

  beat_t exp_q [$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    rdy_mode = 1;          // 0: hold low, 1: hold high, 2: toggle while valid
  int    t_first_vld = 0;
  int    t_last_hs = 0;
  int    gap0 = 0;
  int    bi = 0;                // beats accepted in the current map
  logic  stall_prev = 1'b0;
  logic  vld_prev = 1'b0;
  beat_t held = '0;
  beat_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic beat_t cur_beat();
    return {ob.out_data, ob.out_pos, ob.out_ch, ob.out_last};
  endfunction

  // out_ready driver: changes just after each rising edge.
  initial begin
    ob.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ob.out_ready = 1'b0;
        2:       ob.out_ready = ob.out_valid ? ~ob.out_ready : 1'b1;
        default: ob.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks held outputs on stalls.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
        bi = 0;
        vld_prev = 1'b0;
      end else begin
        if (stall_prev) check("stall_hold", {ob.out_valid, cur_beat()}, {1'b1, held});
        if (ob.out_valid && !vld_prev) t_first_vld = cyc;
        if (ob.out_valid && ob.out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: actual %0h, required no beat (cycle %0d)", cur_beat(), cyc);
          end else begin
            e = exp_q.pop_front();
            check("beat", cur_beat(), e);
          end
          bi++;
          if (ob.out_pos == 0 && ob.out_ch == 0) gap0 = cyc - t_last_hs;
          if (ob.out_last) begin
            t_last_hs = cyc;
            bi = 0;
          end
        end
        stall_prev = ob.out_valid && !ob.out_ready;
        held = cur_beat();
        vld_prev = ob.out_valid;
      end
    end
  end

  // One image: ch k of pos p = base + p*16 + k; expected beats queued when pushed.
  task automatic feed(input int base, input bit push, input int npos);
    for (int p = 0; p < npos; p++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      for (int k = 0; k < CH_N; k++) begin
        logic [OUT_BITS-1:0] v;
        v = OUT_BITS'(base + p * CH_N + k);
        in_pix16[k * OUT_BITS +: OUT_BITS] = v;
        if (push) exp_q.push_back({v, POS_W'(p), CH_W'(k), (p == POS_N - 1 && k == CH_N - 1)});
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ob.out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {ob.out_valid, 32'(exp_q.size())}, 0);
  endtask

  task automatic wait_full(input logic [1:0] want, input int budget, input string name);
    int n;
    n = 0;
    while (bufs_full != want && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, bufs_full, want);
  endtask

  task automatic check_zero(input string name);
    check(name, {ob.out_valid, ob.out_data, ob.out_pos, ob.out_ch, ob.out_last, bufs_full, ovf}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("reset_outputs");

    // 1: single image, always ready; first beat one cycle after the 25th write.
    rdy_mode = 1;
    feed(0, 1'b1, POS_N);
    @(negedge clk);
    check("t1_pre_latency", {ob.out_valid, bufs_full}, {1'b0, 2'b01});
    @(negedge clk);
    check("t1_first_beat", {ob.out_valid, ob.out_pos, ob.out_ch, ob.out_data},
          {1'b1, POS_W'(0), CH_W'(0), 16'd0});
    wait_drain(BEAT_N + 50, "t1_drain");
    check("t1_span", 64'(t_last_hs - t_first_vld), BEAT_N - 1);
    check("t1_bufs_empty", bufs_full, 2'b00);

    // 2: ready toggling; first beat stalls, then every other cycle.
    rdy_mode = 2;
    feed(0, 1'b1, POS_N);
    wait_drain(2 * BEAT_N + 50, "t2_drain");
    check("t2_span", 64'(t_last_hs - t_first_vld), 2 * BEAT_N - 1);
    rdy_mode = 1;

    // 3: two images back to back, second bank chained with no bubble.
    feed(0, 1'b1, POS_N);
    feed(1000, 1'b1, POS_N);
    wait_drain(2 * BEAT_N + 100, "t3_drain");
    check("t3_no_bubble", 64'(gap0), 1);

    // 4: stalled consumer, third image dropped, then a fourth image refills bank 0.
    rdy_mode = 0;
    feed(0, 1'b1, POS_N);
    feed(1000, 1'b1, POS_N);
    @(negedge clk);
    check("t4_both_full", {bufs_full, ovf}, {2'b11, 1'b0});
    feed(2000, 1'b0, POS_N);
    @(negedge clk);
    check("t4_ovf_set", {bufs_full, ovf}, {2'b11, 1'b1});
    rdy_mode = 1;
    wait_full(2'b10, BEAT_N + 50, "t4_bank0_freed");
    feed(3000, 1'b1, POS_N);
    wait_drain(2 * BEAT_N + 100, "t4_drain");
    check("t4_ovf_sticky", ovf, 1'b1);
    check("t4_bufs_empty", bufs_full, 2'b00);

    // 5: negative data is passed bit-exact.
    feed(32'h8000, 1'b1, POS_N);
    wait_drain(BEAT_N + 50, "t5_drain");

    // 6: reset mid-stream, then mid-fill, then a clean image.
    feed(5000, 1'b1, POS_N);
    n = 0;
    while (bi != 137 && n < BEAT_N + 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_beat137", 64'(bi), 137);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_zero("t6_rst_stream");

    feed(6000, 1'b0, 12);
    in_valid = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_zero("t6_rst_fill");
    feed(7000, 1'b1, POS_N);
    wait_drain(BEAT_N + 50, "t6_drain");
    check("t6_bufs_empty", bufs_full, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
